dbg_word_viewer: RTL and testbench
==================================

Name: dbg_word_viewer

Overview:
- Paged debug-word viewer for the development chassis.
- Accepts NUM_WORDS debug words of WORD_W bits and shows one of them on dbg_word_o, which the team feeds to the existing per-nibble segment decoders.
- The operator selects the page in one of two ways: a debounced pushbutton step, or an auto-scroll mode. A freeze input holds the current page and its value.
- Sits in the chassis between the DUT's debug outputs and the hex-display decoders.

Parameters:
NUM_WORDS, 4, number of debug words; must be at least 2; any value is legal, not only powers of 2.
WORD_W, 16, bits per word; must be a multiple of 4.
DEBOUNCE_CYC, 16, consecutive stable cycles required before the debounced button changes state; must be at least 1.
SCROLL_CYC, 8, cycles between automatic advances in scroll mode; must be at least 2.
IDX_W, derived, $clog2(NUM_WORDS); not user-set.

Ports:
dbg_clock_i  in  1  single clock for all logic
dbg_reset_i  in  1  reset; synchronous, active-high
dbg_words_i  in  NUM_WORDS*WORD_W  word k sits at bits [k*WORD_W +: WORD_W]
dbg_next_i  in  1  raw pushbutton, active-high, asynchronous to the clock, bouncy
dbg_scroll_i  in  1  level; high enables auto-advance
dbg_freeze_i  in  1  level; high holds the displayed index and word
dbg_word_o  out  WORD_W  currently displayed word (registered)
dbg_index_o  out  IDX_W  index of the displayed word (registered)
dbg_frozen_o  out  1  registered copy of dbg_freeze_i; drives a feedback LED

Behaviour:
- Reset (takes effect at the clock edge while dbg_reset_i is high):
  - dbg_word_o=0, dbg_index_o=0, dbg_frozen_o=0.
  - Sync flops, debounced state, debounce counter and scroll counter all cleared to 0.
- Synchroniser: dbg_next_i passes through two flops (s1, s2). Nothing else samples the raw input.
- Debouncer:
  - The counter increments each cycle that s2 differs from the debounced state.
  - The counter clears to 0 on any cycle where s2 equals the debounced state.
  - When the counter reaches DEBOUNCE_CYC-1 while s2 still differs, the debounced state takes s2 and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles never change the debounced state.
- Button advance:
  - A one-cycle internal pulse is registered on each debounced 0->1 transition. Release produces no pulse.
  - A clean press held high is seen at edge E. The index increments at edge E+DEBOUNCE_CYC+2.
- Scroll advance:
  - While dbg_scroll_i=1 and not frozen, the scroll counter counts 0..SCROLL_CYC-1.
  - On the cycle it equals SCROLL_CYC-1 it wraps to 0 and generates an advance.
  - dbg_scroll_i=0 clears the counter. Consequently the first advance comes SCROLL_CYC cycles after scroll is raised.
- Index update:
  - On an advance, index becomes index+1, wrapping from NUM_WORDS-1 to 0.
  - Index values of NUM_WORDS and above never occur.
  - A button advance and a scroll advance in the same cycle move the index by exactly +1, not +2.
- Word register:
  - Each non-frozen cycle, dbg_word_o takes dbg_words_i slice [next_index], where next_index is the value dbg_index_o takes at the same edge.
  - dbg_word_o and dbg_index_o are therefore always coherent. Live input changes appear one cycle later.
- Freeze:
  - dbg_frozen_o follows dbg_freeze_i with one cycle of delay.
  - While dbg_freeze_i=1: dbg_word_o and dbg_index_o hold; the scroll counter holds its value; button advance pulses are discarded, not queued.
  - The synchroniser and debouncer keep running during freeze. A press held across the end of freeze therefore does not generate a late advance.
- Reset mid-operation: all state returns to reset values at the reset edge, including any pending debounce count or scroll count.
  - A button held through reset release yields exactly one advance, DEBOUNCE_CYC+2 edges after the first post-reset edge.

Test Plan:
- Reset values: NUM_WORDS=3, WORD_W=16, words {0x1234, 0xABCD, 0x5A5A}; release reset -> index_o=0 and word_o=0x1234 one cycle after release.
- Debounce filter: DEBOUNCE_CYC=4; pulse dbg_next_i high for 3 cycles, three times -> index_o stays 0; then hold high 20 cycles -> index_o=1 exactly DEBOUNCE_CYC+2 edges after the first sampled high, and no second step while held.
- Wrap, non-power-of-2: three clean presses from index 0 -> index_o steps 1, 2, 0 and word_o steps 0xABCD, 0x5A5A, 0x1234.
- Scroll and collision: SCROLL_CYC=5, raise scroll -> index advances every 5 cycles; force a debounced button edge in the same cycle as a scroll advance -> index moves by exactly 1.
- Freeze: freeze at index 1 and change word 1 input to 0xFFFF -> word_o stays 0xABCD and presses are ignored; unfreeze -> word_o=0xFFFF next cycle with index_o unchanged, then scroll resumes from its held count.
- Reset mid-debounce: assert reset with the debounce counter at 2 and scroll enabled -> all outputs and counters are 0; a button held through reset gives a single advance at the specified latency.

Source files
------------

// File: rtl/dbg_word_viewer.sv
// Paged debug-word viewer: selects one of NUM_WORDS debug words for the hex display.
// Paging comes from a debounced pushbutton or an auto-scroll timer, and a freeze input holds the display.
module dbg_word_viewer #(
   parameter  int NUM_WORDS    = 4,
   parameter  int WORD_W       = 16,
   parameter  int DEBOUNCE_CYC = 16,
   parameter  int SCROLL_CYC   = 8,
   localparam int IDX_W        = $clog2(NUM_WORDS)
) (
   input  logic                        dbg_clock_i,
   input  logic                        dbg_reset_i,
   input  logic [NUM_WORDS*WORD_W-1:0] dbg_words_i,
   input  logic                        dbg_next_i,
   input  logic                        dbg_scroll_i,
   input  logic                        dbg_freeze_i,
   output logic [WORD_W-1:0]           dbg_word_o,
   output logic [IDX_W-1:0]            dbg_index_o,
   output logic                        dbg_frozen_o
);

   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int SC_W = $clog2(SCROLL_CYC);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_deb;
   logic [DB_W-1:0]   r_db_cnt;
   logic              r_btn_pulse;
   logic [SC_W-1:0]   r_scroll_cnt;
   logic [IDX_W-1:0]  r_index;
   logic [WORD_W-1:0] r_word;
   logic              r_frozen;

   logic              w_deb_flip;
   logic              w_scroll_adv;
   logic              w_advance;
   logic [IDX_W-1:0]  w_next_index;

   always_comb begin
      w_deb_flip   = (r_sync2 != r_deb) && (r_db_cnt == DB_LAST);
      w_scroll_adv = dbg_scroll_i && !dbg_freeze_i && (r_scroll_cnt == SC_LAST);
      // NOTE: button and scroll advances are OR-ed, so a coincident pair steps the index once.
      w_advance    = (r_btn_pulse || w_scroll_adv) && !dbg_freeze_i;
      w_next_index = r_index;
      if (w_advance) begin
         w_next_index = (r_index == IDX_LAST) ? '0 : r_index + 1'b1;
      end
   end

   // NOTE: the synchroniser and debouncer ignore freeze so a press spanning it never fires late.
   always_ff @(posedge dbg_clock_i) begin
      if (dbg_reset_i) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_deb       <= 1'b0;
         r_db_cnt    <= '0;
         r_btn_pulse <= 1'b0;
      end else begin
         r_sync1     <= dbg_next_i;
         r_sync2     <= r_sync1;
         r_btn_pulse <= w_deb_flip && r_sync2;
         if (r_sync2 == r_deb) begin
            r_db_cnt <= '0;
         end else if (w_deb_flip) begin
            r_deb    <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge dbg_clock_i) begin
      if (dbg_reset_i) begin
         r_scroll_cnt <= '0;
      end else if (!dbg_scroll_i) begin
         r_scroll_cnt <= '0;
      end else if (!dbg_freeze_i) begin
         r_scroll_cnt <= (r_scroll_cnt == SC_LAST) ? '0 : r_scroll_cnt + 1'b1;
      end
   end

   // The word is fetched with the index it will be shown with, keeping the pair coherent.
   always_ff @(posedge dbg_clock_i) begin
      if (dbg_reset_i) begin
         r_index  <= '0;
         r_word   <= '0;
         r_frozen <= 1'b0;
      end else begin
         r_frozen <= dbg_freeze_i;
         if (!dbg_freeze_i) begin
            r_index <= w_next_index;
            r_word  <= dbg_words_i[int'(w_next_index)*WORD_W +: WORD_W];
         end
      end
   end

   assign dbg_word_o   = r_word;
   assign dbg_index_o  = r_index;
   assign dbg_frozen_o = r_frozen;

endmodule

// File: tb/tb_dbg_word_viewer.sv
// Directed bench for dbg_word_viewer: NUM_WORDS=3, WORD_W=16, DEBOUNCE_CYC=4, SCROLL_CYC=5.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_dbg_word_viewer;

   localparam int NUM_WORDS    = 3;
   localparam int WORD_W       = 16;
   localparam int DEBOUNCE_CYC = 4;
   localparam int SCROLL_CYC   = 5;
   localparam int IDX_W        = $clog2(NUM_WORDS);

   logic                        clk = 1'b0;
   logic                        rst;
   logic [NUM_WORDS*WORD_W-1:0] words;
   logic                        next_btn;
   logic                        scroll;
   logic                        freeze;
   logic [WORD_W-1:0]           word_o;
   logic [IDX_W-1:0]            index_o;
   logic                        frozen_o;

   int n_cmp = 0;
   int n_err = 0;

   dbg_word_viewer #(
      .NUM_WORDS    (NUM_WORDS),
      .WORD_W       (WORD_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .SCROLL_CYC   (SCROLL_CYC)
   ) u_dut (
      .dbg_clock_i  (clk),
      .dbg_reset_i  (rst),
      .dbg_words_i  (words),
      .dbg_next_i   (next_btn),
      .dbg_scroll_i (scroll),
      .dbg_freeze_i (freeze),
      .dbg_word_o   (word_o),
      .dbg_index_o  (index_o),
      .dbg_frozen_o (frozen_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_view(input string tag, input int idx, input logic [15:0] wrd);
      check({tag, ".index"}, 32'(index_o), 32'(idx));
      check({tag, ".word"}, 32'(word_o), 32'(wrd));
   endtask

   // Clean press: long enough to debounce both edges, then fully released.
   task automatic press();
      next_btn = 1'b1;
      wait_neg(10);
      next_btn = 1'b0;
      wait_neg(10);
   endtask

   initial begin
      rst      = 1'b1;
      words    = {16'h5A5A, 16'hABCD, 16'h1234};
      next_btn = 1'b0;
      scroll   = 1'b0;
      freeze   = 1'b0;

      // Reset values, then first word one cycle after release.
      wait_neg(3);
      check_view("reset", 0, 16'h0000);
      check("reset.frozen", 32'(frozen_o), 32'd0);
      rst = 1'b0;
      wait_neg(1);
      check_view("post_reset", 0, 16'h1234);

      // Three 3-cycle glitches are filtered.
      for (int g = 0; g < 3; g++) begin
         next_btn = 1'b1;
         wait_neg(3);
         next_btn = 1'b0;
         wait_neg(5);
      end
      wait_neg(8);
      check_view("glitch", 0, 16'h1234);

      // Held press: first sampled at edge E, index steps at E+DEBOUNCE_CYC+2.
      next_btn = 1'b1;
      wait_neg(DEBOUNCE_CYC + 2);
      check("hold.before", 32'(index_o), 32'd0);
      wait_neg(1);
      check_view("hold.step", 1, 16'hABCD);
      wait_neg(13);
      check("hold.no_repeat", 32'(index_o), 32'd1);
      next_btn = 1'b0;
      wait_neg(10);
      check("release.no_step", 32'(index_o), 32'd1);

      // Wrap on a non-power-of-2 word count.
      press(); check_view("wrap.a", 2, 16'h5A5A);
      press(); check_view("wrap.b", 0, 16'h1234);
      press(); check_view("wrap.c", 1, 16'hABCD);
      press(); check_view("wrap.d", 2, 16'h5A5A);
      press(); check_view("wrap.e", 0, 16'h1234);

      // Scroll: raised before edge R, advances at R+4, R+9, ...
      scroll = 1'b1;
      wait_neg(4);                       // n(3)
      check("scroll.before", 32'(index_o), 32'd0);
      wait_neg(1);                       // n(4)
      check_view("scroll.1", 1, 16'hABCD);
      wait_neg(5);                       // n(9)
      check("scroll.2", 32'(index_o), 32'd2);
      wait_neg(5);                       // n(14)
      check("scroll.3", 32'(index_o), 32'd0);
      wait_neg(3);                       // n(17): press seen at R+18, pulse acts at R+24
      next_btn = 1'b1;
      wait_neg(2);                       // n(19)
      check("scroll.4", 32'(index_o), 32'd1);
      wait_neg(4);                       // n(23)
      check("collide.before", 32'(index_o), 32'd1);
      wait_neg(1);                       // n(24)
      check_view("collide.plus1", 2, 16'h5A5A);
      wait_neg(5);                       // n(29)
      check("collide.after", 32'(index_o), 32'd0);
      scroll   = 1'b0;
      next_btn = 1'b0;
      wait_neg(10);
      check("scroll_off", 32'(index_o), 32'd0);

      // Freeze with a live word change and a press inside the freeze window.
      press();
      check_view("freeze.setup", 1, 16'hABCD);
      scroll = 1'b1;                     // scroll count reaches 2 after R+1
      wait_neg(2);                       // n(1)
      freeze = 1'b1;
      words[WORD_W +: WORD_W] = 16'hFFFF;
      wait_neg(1);                       // n(2)
      check_view("freeze.hold", 1, 16'hABCD);
      check("freeze.led", 32'(frozen_o), 32'd1);
      next_btn = 1'b1;                   // pulse lands at R+9, inside freeze
      wait_neg(9);                       // n(11)
      check_view("freeze.press_ignored", 1, 16'hABCD);
      freeze = 1'b0;
      wait_neg(1);                       // n(12)
      check_view("unfreeze.live", 1, 16'hFFFF);
      check("unfreeze.led", 32'(frozen_o), 32'd0);
      wait_neg(1);                       // n(13)
      check("resume.before", 32'(index_o), 32'd1);
      wait_neg(1);                       // n(14): held count 2 resumes -> 3, 4, advance
      check_view("resume.step", 2, 16'h5A5A);
      wait_neg(4);                       // n(18)
      check("freeze.no_late_press", 32'(index_o), 32'd2);
      scroll   = 1'b0;
      next_btn = 1'b0;
      words[WORD_W +: WORD_W] = 16'hABCD;
      wait_neg(10);

      // Reset mid-debounce with scroll running; button held through reset.
      next_btn = 1'b1;                   // first sampled at edge R
      wait_neg(1);                       // n(0)
      scroll = 1'b1;
      wait_neg(3);                       // n(3): debounce count is 2
      rst = 1'b1;
      wait_neg(1);                       // n(4): reset applied at R+4
      check_view("midreset", 0, 16'h0000);
      check("midreset.frozen", 32'(frozen_o), 32'd0);
      rst = 1'b0;                        // first post-reset edge R+5
      wait_neg(4);                       // n(8)
      check("midreset.scroll_before", 32'(index_o), 32'd0);
      wait_neg(1);                       // n(9): scroll count restarted from 0
      check_view("midreset.scroll", 1, 16'hABCD);
      wait_neg(1);                       // n(10)
      check("midreset.btn_before", 32'(index_o), 32'd1);
      wait_neg(1);                       // n(11): R+5+DEBOUNCE_CYC+2
      check_view("midreset.btn", 2, 16'h5A5A);
      scroll = 1'b0;
      wait_neg(9);
      check("midreset.single", 32'(index_o), 32'd2);
      next_btn = 1'b0;
      wait_neg(10);
      check("final.index", 32'(index_o), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
